// File: rtl/dispenser_pkg.sv
// Shared types and constants for the ticket/change dispenser: FSM states,
// coin denominations, field widths and the coin-value helper.
package dispenser_pkg;

  localparam int REFUND_W = 7;
  localparam int TICKET_W = 3;
  localparam int GAP_W    = 3;

  localparam logic [REFUND_W-1:0] COIN10 = 7'd10;
  localparam logic [REFUND_W-1:0] COIN5  = 7'd5;
  localparam logic [REFUND_W-1:0] COIN1  = 7'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TICKET,
    S_CHANGE,
    S_GAP,
    S_DONE
  } state_e;

  typedef struct packed {
    logic c10;
    logic c5;
    logic c1;
  } coin_sel_t;

  function automatic logic [REFUND_W-1:0] coin_value(input coin_sel_t sel);
    logic [REFUND_W-1:0] val;
    val = '0;
    if (sel.c10)     val = COIN10;
    else if (sel.c5) val = COIN5;
    else if (sel.c1) val = COIN1;
    return val;
  endfunction

endpackage

// File: rtl/dispenser_if.sv
// Request, inventory-load and payout signals of the dispenser, bundled with
// a master (requester) and slave (dispenser) view.
interface dispenser_if
  import dispenser_pkg::*;
#(
  parameter int INV_W = 8
);
  logic                req_valid;
  logic                req_ready;
  logic [TICKET_W-1:0] req_tickets;
  logic [REFUND_W-1:0] req_refund;
  logic                inv_load;
  logic [INV_W-1:0]    inv10_in;
  logic [INV_W-1:0]    inv5_in;
  logic [INV_W-1:0]    inv1_in;
  logic                ticket_pulse;
  logic                coin10_pulse;
  logic                coin5_pulse;
  logic                coin1_pulse;
  logic                busy;
  logic                done;
  logic                short;
  logic [REFUND_W-1:0] owed;

  modport master (
    output req_valid, req_tickets, req_refund, inv_load, inv10_in, inv5_in, inv1_in,
    input  req_ready, ticket_pulse, coin10_pulse, coin5_pulse, coin1_pulse,
           busy, done, short, owed
  );

  modport slave (
    input  req_valid, req_tickets, req_refund, inv_load, inv10_in, inv5_in, inv1_in,
    output req_ready, ticket_pulse, coin10_pulse, coin5_pulse, coin1_pulse,
           busy, done, short, owed
  );
endinterface

// File: rtl/ticket_dispenser_coin_select.sv
// Greedy coin chooser: largest denomination that fits the remaining amount
// and is still in stock; none_o when nothing can be paid.
module coin_select
  import dispenser_pkg::*;
(
  input  logic [REFUND_W-1:0] remaining_i,
  input  logic                has10_i,
  input  logic                has5_i,
  input  logic                has1_i,
  output coin_sel_t           sel_o,
  output logic                none_o
);

  always_comb begin
    sel_o = '0;
    if (remaining_i >= COIN10 && has10_i)     sel_o.c10 = 1'b1;
    else if (remaining_i >= COIN5 && has5_i)  sel_o.c5  = 1'b1;
    else if (remaining_i >= COIN1 && has1_i)  sel_o.c1  = 1'b1;
  end

  assign none_o = (sel_o == '0);

endmodule

// File: rtl/ticket_dispenser.sv
// Ticket and change dispenser: issues the requested tickets, then pays the
// refund greedily from three coin inventories, one pulse at a time.
module ticket_dispenser
  import dispenser_pkg::*;
#(
  parameter int PULSE_GAP = 1,
  parameter int INV_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  dispenser_if.slave  bus
);

  state_e              state_q, state_d;
  state_e              pend_q, pend_d;
  logic [TICKET_W-1:0] tickets_q, tickets_d;
  logic [REFUND_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                short_q, short_d;
  logic [INV_W-1:0]    inv10_q, inv10_d;
  logic [INV_W-1:0]    inv5_q, inv5_d;
  logic [INV_W-1:0]    inv1_q, inv1_d;

  coin_sel_t           sel;
  logic                sel_none;
  logic                fire;
  state_e              next_pend;
  logic                ticket_p, c10_p, c5_p, c1_p, done_p;

  coin_select u_coin_select (
    .remaining_i (rem_q),
    .has10_i     (inv10_q != '0),
    .has5_i      (inv5_q != '0),
    .has1_i      (inv1_q != '0),
    .sel_o       (sel),
    .none_o      (sel_none)
  );

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    tickets_d = tickets_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    short_d   = short_q;
    inv10_d   = inv10_q;
    inv5_d    = inv5_q;
    inv1_d    = inv1_q;
    fire      = 1'b0;
    next_pend = S_DONE;
    ticket_p  = 1'b0;
    c10_p     = 1'b0;
    c5_p      = 1'b0;
    c1_p      = 1'b0;
    done_p    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Load is applied in the same cycle as an accept, so payout sees it.
        if (bus.inv_load) begin
          inv10_d = bus.inv10_in;
          inv5_d  = bus.inv5_in;
          inv1_d  = bus.inv1_in;
        end
        if (bus.req_valid) begin
          tickets_d = bus.req_tickets;
          rem_d     = bus.req_refund;
          short_d   = 1'b0;
          if (bus.req_tickets != '0)     state_d = S_TICKET;
          else if (bus.req_refund != '0) state_d = S_CHANGE;
          else                           state_d = S_DONE;
        end
      end
      S_TICKET: begin
        ticket_p  = 1'b1;
        tickets_d = tickets_q - 1'b1;
        fire      = 1'b1;
        if (tickets_q != TICKET_W'(1)) next_pend = S_TICKET;
        else if (rem_q != '0)          next_pend = S_CHANGE;
        else                           next_pend = S_DONE;
      end
      S_CHANGE: begin
        if (!sel_none) begin
          c10_p = sel.c10;
          c5_p  = sel.c5;
          c1_p  = sel.c1;
          rem_d = rem_q - coin_value(sel);
          if (sel.c10) inv10_d = inv10_q - 1'b1;
          if (sel.c5)  inv5_d  = inv5_q - 1'b1;
          if (sel.c1)  inv1_d  = inv1_q - 1'b1;
          fire      = 1'b1;
          next_pend = (rem_d != '0) ? S_CHANGE : S_DONE;
        end else begin
          short_d = (rem_q != '0);
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = pend_q;
        else             gap_d   = gap_q - 1'b1;
      end
      S_DONE: begin
        done_p  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A pulse either goes straight to the next pulse state or parks in GAP.
    if (fire) begin
      pend_d = next_pend;
      if (PULSE_GAP == 0) begin
        state_d = next_pend;
      end else begin
        state_d = S_GAP;
        gap_d   = GAP_W'(PULSE_GAP - 1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pend_q    <= S_IDLE;
      tickets_q <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      short_q   <= 1'b0;
      inv10_q   <= '0;
      inv5_q    <= '0;
      inv1_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      tickets_q <= tickets_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      short_q   <= short_d;
      inv10_q   <= inv10_d;
      inv5_q    <= inv5_d;
      inv1_q    <= inv1_d;
    end
  end

  // Reset gates the state-derived outputs so an aborted payout emits nothing.
  assign bus.req_ready    = !reset && (state_q == S_IDLE);
  assign bus.busy         = !reset && (state_q != S_IDLE);
  assign bus.ticket_pulse = !reset && ticket_p;
  assign bus.coin10_pulse = !reset && c10_p;
  assign bus.coin5_pulse  = !reset && c5_p;
  assign bus.coin1_pulse  = !reset && c1_p;
  assign bus.done         = !reset && done_p;
  assign bus.short        = short_q;
  assign bus.owed         = rem_q;

endmodule

// File: tb/tb_ticket_dispenser.sv
// Bench for ticket_dispenser: two instances (PULSE_GAP 0 and 2) share stimulus
// and are compared cycle by cycle against a trace-level payout model.
module tb_ticket_dispenser;
  import dispenser_pkg::*;

  localparam int INV_W = 8;
  localparam logic [4:0] P_DONE = 5'b10000;
  localparam logic [4:0] P_TK   = 5'b01000;
  localparam logic [4:0] P_C10  = 5'b00100;
  localparam logic [4:0] P_C5   = 5'b00010;
  localparam logic [4:0] P_C1   = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             req_valid;
  logic [2:0]       req_tickets;
  logic [6:0]       req_refund;
  logic             inv_load;
  logic [INV_W-1:0] inv10_in, inv5_in, inv1_in;

  dispenser_if #(.INV_W(INV_W)) if0 ();
  dispenser_if #(.INV_W(INV_W)) if2 ();

  assign if0.req_valid = req_valid;   assign if2.req_valid = req_valid;
  assign if0.req_tickets = req_tickets; assign if2.req_tickets = req_tickets;
  assign if0.req_refund = req_refund; assign if2.req_refund = req_refund;
  assign if0.inv_load = inv_load;     assign if2.inv_load = inv_load;
  assign if0.inv10_in = inv10_in;     assign if2.inv10_in = inv10_in;
  assign if0.inv5_in = inv5_in;       assign if2.inv5_in = inv5_in;
  assign if0.inv1_in = inv1_in;       assign if2.inv1_in = inv1_in;

  ticket_dispenser #(.PULSE_GAP(0), .INV_W(INV_W)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  ticket_dispenser #(.PULSE_GAP(2), .INV_W(INV_W)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  // Observation word: {ready, busy, short, owed[6:0], done, ticket, c10, c5, c1}
  logic [14:0] w0, w2;
  assign w0 = {if0.req_ready, if0.busy, if0.short, if0.owed, if0.done,
               if0.ticket_pulse, if0.coin10_pulse, if0.coin5_pulse, if0.coin1_pulse};
  assign w2 = {if2.req_ready, if2.busy, if2.short, if2.owed, if2.done,
               if2.ticket_pulse, if2.coin10_pulse, if2.coin5_pulse, if2.coin1_pulse};

  int total = 0;
  int bad   = 0;

  int m10, m5, m1;
  logic [14:0] tq[$];
  logic [14:0] e0[$];
  logic [14:0] e2[$];

  typedef struct {
    bit ld; int i10; int i5; int i1;
    bit bl; int b10; int b5; int b1;
    int tk; int rf;
    int done0; int done2; bit sh; int ow;
  } vec_t;

  vec_t vec [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [14:0] mk(input logic rdy, input logic bsy, input logic sh,
                                     input int ow, input logic [4:0] p);
    return {rdy, bsy, sh, 7'(ow), p};
  endfunction

  // Expected per-cycle words from the cycle after accept until idle again.
  task automatic model(input int gap, input int tk, input int rf,
                       output int n10, output int n5, output int n1);
    int rem;
    int l10, l5, l1;
    bit sh;
    rem = rf; l10 = m10; l5 = m5; l1 = m1;
    tq.delete();
    for (int t = 0; t < tk; t++) begin
      tq.push_back(mk(1'b0, 1'b1, 1'b0, rem, P_TK));
      repeat (gap) tq.push_back(mk(1'b0, 1'b1, 1'b0, rem, 5'b0));
    end
    while (rem > 0) begin
      logic [4:0] p;
      int v;
      if (rem >= 10 && l10 > 0)     begin p = P_C10; v = 10; l10--; end
      else if (rem >= 5 && l5 > 0)  begin p = P_C5;  v = 5;  l5--;  end
      else if (l1 > 0)              begin p = P_C1;  v = 1;  l1--;  end
      else break;
      tq.push_back(mk(1'b0, 1'b1, 1'b0, rem, p));
      rem -= v;
      repeat (gap) tq.push_back(mk(1'b0, 1'b1, 1'b0, rem, 5'b0));
    end
    sh = (rem > 0);
    if (sh) tq.push_back(mk(1'b0, 1'b1, 1'b0, rem, 5'b0));
    tq.push_back(mk(1'b0, 1'b1, sh, rem, P_DONE));
    tq.push_back(mk(1'b1, 1'b0, sh, rem, 5'b0));
    n10 = l10; n5 = l5; n1 = l1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(if0.req_ready && if2.req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, " ready"}, {30'b0, if0.req_ready, if2.req_ready}, 32'd3);
  endtask

  task automatic txn(input string nm, input bit ld, input int i10, input int i5, input int i1,
                     input bit bl, input int b10, input int b5, input int b1,
                     input int tk, input int rf,
                     output int lat0, output int lat2, output logic [14:0] fin0);
    int n10, n5, n1, len;
    wait_ready(nm);
    if (ld) begin m10 = i10; m5 = i5; m1 = i1; end
    model(0, tk, rf, n10, n5, n1); e0 = tq;
    model(2, tk, rf, n10, n5, n1); e2 = tq;
    m10 = n10; m5 = n5; m1 = n1;
    req_valid = 1'b1; req_tickets = 3'(tk); req_refund = 7'(rf);
    inv_load = ld; inv10_in = 8'(i10); inv5_in = 8'(i5); inv1_in = 8'(i1);
    @(posedge clk);
    lat0 = -1; lat2 = -1; fin0 = '0;
    len = (e0.size() > e2.size()) ? e0.size() : e2.size();
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check({nm, " g0"}, 32'(w0), 32'(e0[(k < e0.size()) ? k : e0.size() - 1]));
      check({nm, " g2"}, 32'(w2), 32'(e2[(k < e2.size()) ? k : e2.size() - 1]));
      if (w0[4] && lat0 < 0) begin lat0 = k + 1; fin0 = w0; end
      if (w2[4] && lat2 < 0) lat2 = k + 1;
      if (k == 0) begin
        req_valid = 1'b0;
        inv_load = bl; inv10_in = 8'(b10); inv5_in = 8'(b5); inv1_in = 8'(b1);
      end else begin
        inv_load = 1'b0;
      end
    end
    inv_load = 1'b0;
  endtask

  initial begin
    int lat0, lat2;
    logic [14:0] fin0;

    vec[0] = '{1'b1, 10, 10, 10, 1'b0, 0, 0, 0, 2, 17,  7, 19, 1'b0, 0};
    vec[1] = '{1'b1,  0,  1,  2, 1'b0, 0, 0, 0, 0, 13,  5, 11, 1'b1, 6};
    vec[2] = '{1'b0,  0,  0,  0, 1'b0, 0, 0, 0, 0,  0,  1,  1, 1'b0, 0};
    vec[3] = '{1'b1,  5,  5,  5, 1'b0, 0, 0, 0, 1,  5,  3,  7, 1'b0, 0};
    vec[4] = '{1'b0,  0,  0,  0, 1'b1, 0, 0, 0, 3, 16,  7, 19, 1'b0, 0};
    vec[5] = '{1'b0,  0,  0,  0, 1'b0, 0, 0, 0, 0,  8,  5, 13, 1'b0, 0};
    vec[6] = '{1'b1,  0,  0,  0, 1'b0, 0, 0, 0, 0,  4,  2,  2, 1'b1, 4};
    vec[7] = '{1'b1,  3,  0,  7, 1'b0, 0, 0, 0, 1, 27, 11, 31, 1'b0, 0};

    reset = 1'b1; req_valid = 1'b0; req_tickets = '0; req_refund = '0;
    inv_load = 1'b0; inv10_in = '0; inv5_in = '0; inv1_in = '0;
    m10 = 0; m5 = 0; m1 = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset g0", 32'(w0), 32'd0);
    check("reset g2", 32'(w2), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ready after reset g0", 32'(w0), 32'(mk(1'b1, 1'b0, 1'b0, 0, 5'b0)));
    check("ready after reset g2", 32'(w2), 32'(mk(1'b1, 1'b0, 1'b0, 0, 5'b0)));

    for (int i = 0; i < 8; i++) begin
      txn($sformatf("v%0d", i), vec[i].ld, vec[i].i10, vec[i].i5, vec[i].i1,
          vec[i].bl, vec[i].b10, vec[i].b5, vec[i].b1, vec[i].tk, vec[i].rf,
          lat0, lat2, fin0);
      check($sformatf("v%0d done lat g0", i), 32'(lat0), 32'(vec[i].done0));
      check($sformatf("v%0d done lat g2", i), 32'(lat2), 32'(vec[i].done2));
      check($sformatf("v%0d short/owed", i), {24'b0, fin0[12], fin0[11:5]},
            {24'b0, vec[i].sh, 7'(vec[i].ow)});
    end

    // Abort: reset lands after the first of three tickets.
    wait_ready("abort");
    req_valid = 1'b1; req_tickets = 3'd3; req_refund = '0; inv_load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort first ticket g0", 32'(w0), 32'(mk(1'b0, 1'b1, 1'b0, 0, P_TK)));
    check("abort first ticket g2", 32'(w2), 32'(mk(1'b0, 1'b1, 1'b0, 0, P_TK)));
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort in reset g0", 32'(w0), 32'd0);
      check("abort in reset g2", 32'(w2), 32'd0);
    end
    @(posedge clk); #1 reset = 1'b0;
    m10 = 0; m5 = 0; m1 = 0;
    repeat (4) begin
      @(negedge clk);
      check("abort idle g0", 32'(w0), 32'(mk(1'b1, 1'b0, 1'b0, 0, 5'b0)));
      check("abort idle g2", 32'(w2), 32'(mk(1'b1, 1'b0, 1'b0, 0, 5'b0)));
    end
    txn("empty inv", 1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 3, lat0, lat2, fin0);
    check("empty inv short/owed", {24'b0, fin0[12], fin0[11:5]}, {24'b0, 1'b1, 7'd3});

    for (int r = 0; r < 25; r++) begin
      txn($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
          1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 40), lat0, lat2, fin0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ticket_dispenser.md
TICKET_DISPENSER -- requirements
Module: ticket_dispenser

Interface
REQ-001 SHALL have parameter PULSE_GAP, default 1: number of idle cycles inserted after every ticket or coin pulse (0 to 7).
REQ-002 SHALL have parameter INV_W, default 8: width of each coin inventory counter.
REQ-003 SHALL use reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have the following ports, listed as name  direction  width  meaning:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  payout request present.
- req_ready  out  1  block idle and able to accept a request.
- req_tickets  in  3  number of tickets to issue (0 to 7).
- req_refund  in  7  change to return (0 to 127).
- inv_load  in  1  load the coin inventories.
- inv10_in, inv5_in, inv1_in  in  INV_W each  inventory load values.
- ticket_pulse  out  1  one-cycle ticket eject.
- coin10_pulse, coin5_pulse, coin1_pulse  out  1 each  one-cycle coin eject.
- busy  out  1  payout in progress.
- done  out  1  one-cycle pulse at payout completion.
- short  out  1  change could not be fully paid; held until the next accept.
- owed  out  7  change still undispensed.

Function
REQ-005 SHALL accept a request on a cycle where req_valid=1 and req_ready=1, capturing req_tickets and req_refund at that cycle.
REQ-006 SHALL drive req_ready=1 only in IDLE, and SHALL clear short at accept.
REQ-007 SHALL implement the states IDLE, TICKET, CHANGE, GAP and DONE.
REQ-008 SHALL transition from IDLE on accept to TICKET if tickets>0, else to CHANGE if refund>0, else to DONE.
REQ-009 SHALL, in TICKET, assert ticket_pulse for one cycle, decrement the ticket count, then go to GAP.
- Ticket count reaching zero SHALL route the next pulse-state to CHANGE, or to DONE if refund=0.
REQ-010 SHALL, in CHANGE, select coins greedily from the remaining refund:
- 10 if remaining>=10 and inv10>0;
- else 5 if remaining>=5 and inv5>0;
- else 1 if remaining>=1 and inv1>0.
REQ-011 SHALL, for each coin paid, pulse the matching coin output for one cycle, subtract its value from the remaining refund, decrement that inventory, then go to GAP.
REQ-012 SHALL, when in CHANGE with remaining>0 and no coin selectable, set short=1 and go to DONE with owed=remaining.
REQ-013 SHALL stay in GAP for PULSE_GAP cycles, then return to the pending pulse state.
- If PULSE_GAP=0, the GAP state SHALL be skipped, giving back-to-back pulses.
REQ-014 SHALL assert done for exactly one cycle in DONE, then return to IDLE; req_ready SHALL rise on the following cycle.
REQ-015 SHALL produce the first pulse on the cycle after accept (latency 1).
REQ-016 SHALL assert at most one of ticket_pulse or the coin pulses on any cycle.
REQ-017 SHALL drive owed as the remaining refund at all times; it SHALL be 0 after a complete payout.
REQ-018 SHALL honour inv_load only in IDLE, overwriting all three inventories; inv_load SHALL be ignored while busy.
- If inv_load and accept coincide, the load SHALL take effect first.
REQ-019 SHALL assert busy in every state other than IDLE.
REQ-020 SHALL never underflow an inventory; inventories SHALL be decremented only on their own pulse.

Reset
REQ-021 SHALL, on reset, enter IDLE and clear all pulses, busy, done, short, owed, the internal counts and all inventories to 0.
REQ-022 SHALL treat reset mid-payout as an abort: no further pulses, no done.
REQ-023 SHALL hold req_ready=0 during reset and drive it to 1 on the first cycle after reset deasserts.

Structure
REQ-024 SHALL place the state enum, the coin denominations (10/5/1) and the width constants (refund 7, tickets 3) in the shared package dispenser_pkg.
REQ-025 SHALL implement greedy coin choice in one combinational sub-module coin_select:
- inputs: remaining amount and the three inventory-nonzero flags;
- outputs: a one-hot coin select and a none flag.

Verification
REQ-026 SHALL cover: inventories 10/10/10, PULSE_GAP=0, tickets=2, refund=17 -> ticket, ticket, coin10, coin5, coin1, coin1 on consecutive cycles, then done with owed=0 and short=0.
REQ-027 SHALL cover: inv10=0, inv5=1, inv1=2, tickets=0, refund=13 -> coin5, coin1, coin1, then done with short=1 and owed=6.
REQ-028 SHALL cover: tickets=0, refund=0 -> done on the cycle after accept, no pulses, req_ready=1 one cycle later.
REQ-029 SHALL cover: PULSE_GAP=2, tickets=1, refund=5 -> ticket pulse at T+1, coin5 at T+4, done at T+7.
REQ-030 SHALL cover: reset asserted after the first of 3 tickets -> no further pulses, no done, all inventories 0, req_ready=1 after reset.
REQ-031 SHALL cover: inv_load while busy -> inventories unchanged; the same load in IDLE -> inventories take the new values.
